fetch_redirect_ctrl: RTL and testbench

//  Owns the fetch PC for the dual-issue front end (2 insts/fetch, PC step 8).

---
 rtl/fetch_redirect_ctrl.sv | 144 ++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner for the dual-issue front end: sequences branch/jump/jr redirects,
// delay-slot fetch and jr operand wait, with exception/eret override.
module fetch_redirect_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'hbfc0_0000,
   parameter logic [31:0] EXC_VECTOR = 32'hbfc0_0380,
   parameter logic [31:0] FETCH_STEP = 32'd8
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_exc_req,
   input  logic        i_eret_req,
   input  logic [31:0] i_cp0_epc,
   input  logic        i_br_req,
   input  logic        i_j_req,
   input  logic        i_jr_req,
   input  logic        i_cf_slot,
   input  logic [31:0] i_cf_pc,
   input  logic [15:0] i_br_offset,
   input  logic [25:0] i_j_index,
   input  logic [31:0] i_jr_data,
   input  logic        i_jr_data_ok,
   output logic [31:0] o_pc,
   output logic        o_redirect,
   output logic        o_if_flush,
   output logic        o_busy
);

   typedef enum logic [1:0] {StIdle, StPendSlot, StWaitJr} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic        r_redirect, w_redirect_nxt;
   logic        r_if_flush, w_if_flush_nxt;
   logic [31:0] r_target, w_target_nxt;
   logic        r_jr_slot, w_jr_slot_nxt;

   logic [31:0] w_seq;
   logic [31:0] w_br_tgt;
   logic [31:0] w_j_tgt;
   logic [31:0] w_cf_tgt;
   logic        w_tgt_known;
   logic        w_cf_req;

   assign w_seq    = i_cf_pc + 32'd4;
   assign w_br_tgt = w_seq + {{14{i_br_offset[15]}}, i_br_offset, 2'b00};
   assign w_j_tgt  = {w_seq[31:28], i_j_index, 2'b00};
   assign w_cf_req = i_br_req | i_j_req | i_jr_req;

   // Simultaneous requests are illegal; resolve j > jr > br anyway.
   always_comb begin
      w_cf_tgt    = w_br_tgt;
      w_tgt_known = 1'b1;
      if (i_j_req) begin
         w_cf_tgt = w_j_tgt;
      end else if (i_jr_req) begin
         w_cf_tgt    = i_jr_data;
         w_tgt_known = i_jr_data_ok;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_redirect_nxt = 1'b0;
      w_if_flush_nxt = 1'b0;
      w_target_nxt   = r_target;
      w_jr_slot_nxt  = r_jr_slot;

      if (i_exc_req || i_eret_req) begin
         w_pc_nxt       = i_exc_req ? EXC_VECTOR : i_cp0_epc;
         w_redirect_nxt = 1'b1;
         w_if_flush_nxt = 1'b1;
         w_state_nxt    = StIdle;
         w_target_nxt   = '0;
         w_jr_slot_nxt  = 1'b0;
      end else if (!i_stall) begin
         unique case (r_state)
            StIdle: begin
               if (!w_cf_req) begin
                  w_pc_nxt = r_pc + FETCH_STEP;
               end else if (!w_tgt_known) begin
                  w_state_nxt   = StWaitJr;
                  w_jr_slot_nxt = i_cf_slot;
               end else if (i_cf_slot) begin
                  // Delay slot sits in the next pair: fetch it first, redirect after.
                  w_target_nxt = w_cf_tgt;
                  w_pc_nxt     = r_pc + FETCH_STEP;
                  w_state_nxt  = StPendSlot;
               end else begin
                  w_pc_nxt       = w_cf_tgt;
                  w_redirect_nxt = 1'b1;
                  w_if_flush_nxt = 1'b1;
               end
            end
            StPendSlot: begin
               w_pc_nxt       = r_target;
               w_redirect_nxt = 1'b1;
               w_if_flush_nxt = 1'b1;
               w_state_nxt    = StIdle;
            end
            StWaitJr: begin
               if (i_jr_data_ok) begin
                  if (r_jr_slot) begin
                     w_target_nxt = i_jr_data;
                     w_pc_nxt     = r_pc + FETCH_STEP;
                     w_state_nxt  = StPendSlot;
                  end else begin
                     w_pc_nxt       = i_jr_data;
                     w_redirect_nxt = 1'b1;
                     w_if_flush_nxt = 1'b1;
                     w_state_nxt    = StIdle;
                  end
               end
            end
            default: w_state_nxt = StIdle;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_pc       <= RESET_PC;
         r_redirect <= 1'b0;
         r_if_flush <= 1'b0;
         r_target   <= '0;
         r_jr_slot  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_redirect <= w_redirect_nxt;
         r_if_flush <= w_if_flush_nxt;
         r_target   <= w_target_nxt;
         r_jr_slot  <= w_jr_slot_nxt;
      end
   end

   assign o_pc       = r_pc;
   assign o_redirect = r_redirect;
   assign o_if_flush = r_if_flush;
   assign o_busy     = (r_state != StIdle);

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed vectors with literal checks, a spec-level
// model compared every cycle, then a seeded random phase against the same model.
module tb_fetch_redirect_ctrl;

   localparam logic [31:0] RST_PC  = 32'hbfc0_0000;
   localparam logic [31:0] EXC_VEC = 32'hbfc0_0380;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall, exc_req, eret_req, br_req, j_req, jr_req, cf_slot, jr_data_ok;
   logic [31:0] cp0_epc, cf_pc, jr_data;
   logic [15:0] br_offset;
   logic [25:0] j_index;
   logic [31:0] pc;
   logic        redirect, if_flush, busy;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   bit          check_en = 1'b0;

   fetch_redirect_ctrl dut (
      .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_exc_req(exc_req),
      .i_eret_req(eret_req), .i_cp0_epc(cp0_epc), .i_br_req(br_req), .i_j_req(j_req),
      .i_jr_req(jr_req), .i_cf_slot(cf_slot), .i_cf_pc(cf_pc), .i_br_offset(br_offset),
      .i_j_index(j_index), .i_jr_data(jr_data), .i_jr_data_ok(jr_data_ok),
      .o_pc(pc), .o_redirect(redirect), .o_if_flush(if_flush), .o_busy(busy)
   );

   always #5 clk = ~clk;

   // Model: a pending delay-slot target and/or an outstanding jr operand.
   typedef struct {
      logic [31:0] pc;
      bit          redirect;
      bit          flush;
      bit          pend;
      bit          wait_jr;
      bit          wslot;
      logic [31:0] tgt;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.pc = RST_PC; r.redirect = 0; r.flush = 0; r.pend = 0; r.wait_jr = 0;
      r.wslot = 0; r.tgt = 0;
      return r;
   endfunction

   function automatic model_t model_next(model_t cur);
      model_t      n;
      logic [31:0] seq, tgt;
      bit          known;
      n = cur;
      n.redirect = 0;
      n.flush    = 0;
      seq = cf_pc + 32'd4;
      if (exc_req || eret_req) begin
         n.pc = exc_req ? EXC_VEC : cp0_epc;
         n.redirect = 1; n.flush = 1; n.pend = 0; n.wait_jr = 0;
      end else if (stall) begin
         n = n;
      end else if (cur.pend) begin
         n.pc = cur.tgt; n.redirect = 1; n.flush = 1; n.pend = 0;
      end else if (cur.wait_jr) begin
         if (jr_data_ok) begin
            n.wait_jr = 0;
            if (cur.wslot) begin
               n.tgt = jr_data; n.pend = 1; n.pc = cur.pc + 32'd8;
            end else begin
               n.pc = jr_data; n.redirect = 1; n.flush = 1;
            end
         end
      end else if (br_req || j_req || jr_req) begin
         known = 1;
         if (j_req) tgt = {seq[31:28], j_index, 2'b00};
         else if (jr_req) begin tgt = jr_data; known = jr_data_ok; end
         else tgt = seq + {{14{br_offset[15]}}, br_offset, 2'b00};
         if (!known) begin
            n.wait_jr = 1; n.wslot = cf_slot;
         end else if (cf_slot) begin
            n.tgt = tgt; n.pend = 1; n.pc = cur.pc + 32'd8;
         end else begin
            n.pc = tgt; n.redirect = 1; n.flush = 1;
         end
      end else begin
         n.pc = cur.pc + 32'd8;
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= model_reset();
      else     m <= model_next(m);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("model_pc", pc, m.pc);
         chk("model_redirect", {31'd0, redirect}, {31'd0, m.redirect});
         chk("model_if_flush", {31'd0, if_flush}, {31'd0, m.flush});
         chk("model_busy", {31'd0, busy}, {31'd0, m.pend | m.wait_jr});
      end
   end

   task automatic clear_inputs();
      stall = 0; exc_req = 0; eret_req = 0; br_req = 0; j_req = 0; jr_req = 0;
      cf_slot = 0; jr_data_ok = 0; cp0_epc = 0; cf_pc = 0; jr_data = 0;
      br_offset = 0; j_index = 0;
   endtask

   task automatic lit(input string name, input logic [31:0] exp_pc, input bit exp_rd,
                      input bit exp_busy);
      chk({name, "_pc"}, pc, exp_pc);
      chk({name, "_redirect"}, {31'd0, redirect}, {31'd0, exp_rd});
      chk({name, "_flush"}, {31'd0, if_flush}, {31'd0, exp_rd});
      chk({name, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
   endtask

   logic [31:0] rnd;

   initial begin
      clear_inputs();
      #1 rst = 1'b1;
      check_en = 1'b1;
      @(negedge clk);
      lit("reset", RST_PC, 0, 0);
      rst = 1'b0;
      @(negedge clk); lit("seq1", 32'hbfc0_0008, 0, 0);
      @(negedge clk); lit("seq2", 32'hbfc0_0010, 0, 0);
      br_req = 1; cf_slot = 0; cf_pc = 32'hbfc0_0010; br_offset = 16'h0004;
      @(negedge clk); lit("br_slot0", 32'hbfc0_0024, 1, 0);
      br_req = 0;
      @(negedge clk); lit("br_after", 32'hbfc0_002c, 0, 0);
      j_req = 1; cf_slot = 1; cf_pc = 32'hbfc0_0014; j_index = 26'h0000100;
      @(negedge clk); lit("j_slot1_ds", 32'hbfc0_0034, 0, 1);
      j_req = 0;
      @(negedge clk); lit("j_slot1_tgt", 32'hb000_0400, 1, 0);
      jr_req = 1; cf_slot = 0; jr_data_ok = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); lit("jr_wait", 32'hb000_0400, 0, 1);
      end
      jr_data = 32'h8000_1000; jr_data_ok = 1;
      @(negedge clk); lit("jr_done", 32'h8000_1000, 1, 0);
      jr_req = 0; jr_data_ok = 0;
      @(negedge clk); lit("jr_after", 32'h8000_1008, 0, 0);
      jr_req = 1; cf_slot = 1; jr_data_ok = 0;
      @(negedge clk); lit("jr_wait2", 32'h8000_1008, 0, 1);
      jr_req = 0; stall = 1; exc_req = 1; jr_data_ok = 1; jr_data = 32'h1234_5678;
      @(negedge clk); lit("exc_in_wait", EXC_VEC, 1, 0);
      exc_req = 0; stall = 0; jr_data_ok = 0;
      @(negedge clk); lit("exc_after", 32'hbfc0_0388, 0, 0);
      exc_req = 1; br_req = 1; cf_slot = 0; cf_pc = 32'hbfc0_0388; br_offset = 16'h0004;
      @(negedge clk); lit("exc_over_br", EXC_VEC, 1, 0);
      exc_req = 0; br_req = 0; eret_req = 1; cp0_epc = 32'h8000_0200;
      @(negedge clk); lit("eret", 32'h8000_0200, 1, 0);
      eret_req = 0; br_req = 1; cf_slot = 0; cf_pc = 32'h8000_0200; br_offset = 16'hfffc;
      @(negedge clk); lit("br_neg", 32'h8000_01f4, 1, 0);
      cf_slot = 1; cf_pc = 32'h8000_01f4; br_offset = 16'h0002;
      @(negedge clk); lit("br_slot1_ds", 32'h8000_01fc, 0, 1);
      br_req = 0; stall = 1;
      @(negedge clk); lit("pend_stall", 32'h8000_01fc, 0, 1);
      stall = 0;
      @(negedge clk); lit("pend_release", 32'h8000_0200, 1, 0);
      jr_req = 1; cf_slot = 1; jr_data_ok = 1; jr_data = 32'h0040_0000;
      @(negedge clk); lit("jr_ok_slot1_ds", 32'h8000_0208, 0, 1);
      jr_req = 0; jr_data_ok = 0;
      @(negedge clk); lit("jr_ok_slot1_tgt", 32'h0040_0000, 1, 0);
      j_req = 1; cf_slot = 1; cf_pc = 32'h0040_0000; j_index = 26'h0;
      @(negedge clk); lit("j_pend", 32'h0040_0008, 0, 1);
      j_req = 0;
      #2 rst = 1'b1;
      #1 lit("reset_mid", RST_PC, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); lit("post_reset", 32'hbfc0_0008, 0, 0);

      for (int c = 0; c < 400; c++) begin
         exc_req  = ($urandom_range(0, 19) == 0);
         eret_req = ($urandom_range(0, 24) == 0);
         stall    = ($urandom_range(0, 4) == 0);
         br_req   = ($urandom_range(0, 5) == 0);
         j_req    = ($urandom_range(0, 9) == 0);
         jr_req   = ($urandom_range(0, 7) == 0);
         cf_slot  = ($urandom_range(0, 1) == 1);
         jr_data_ok = ($urandom_range(0, 2) == 0);
         cf_pc    = {$urandom()} & 32'hffff_fffc;
         jr_data  = {$urandom()} & 32'hffff_fffc;
         cp0_epc  = {$urandom()} & 32'hffff_fffc;
         rnd = $urandom();
         br_offset = rnd[15:0];
         rnd = $urandom();
         j_index = rnd[25:0];
         @(negedge clk);
      end
      clear_inputs();
      repeat (4) @(negedge clk);
      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
